// File: rtl/fb_pkg.sv
// Shared constants, FSM state type and pixel helpers for the double-buffered
// 320x240 frame buffer.
package fb_pkg;

    localparam int FB_WIDTH  = 320;
    localparam int FB_HEIGHT = 240;
    localparam int FB_DEPTH  = 76800;
    localparam int FB_ADDR_W = 17;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        SWAP_WAIT
    } fb_state_e;

    function automatic logic in_frame(input logic [8:0] px, input logic [7:0] py);
        return (px < 9'(FB_WIDTH)) && (py < 8'(FB_HEIGHT));
    endfunction

    // y*320 + x without a multiplier: 320 = 256 + 64.
    function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic [8:0] px, input logic [7:0] py);
        logic [FB_ADDR_W-1:0] yy;
        yy = FB_ADDR_W'(py);
        return (yy << 8) + (yy << 6) + FB_ADDR_W'(px);
    endfunction

    // MSB-first bit replication of a ch_bits-wide channel up to 10 bits.
    function automatic logic [9:0] expand_ch(input logic [9:0] c, input int ch_bits);
        logic [9:0] out;
        logic [3:0] src;
        out = '0;
        for (int i = 0; i < 10; i++) begin
            src = 4'(ch_bits - 1 - (i % ch_bits));
            out[4'(9 - i)] = c[src];
        end
        return out;
    endfunction

endpackage

// File: rtl/frame_buffer_if.sv
// Rasterizer write port: valid/ready pixel writes plus the out-of-range drop pulse.
interface frame_buffer_if #(
    parameter int CH_BITS = 3
);
    logic                 wr_valid;
    logic                 wr_ready;
    logic [8:0]           wr_x;
    logic [7:0]           wr_y;
    logic [3*CH_BITS-1:0] wr_color;
    logic                 wr_drop;

    modport master (
        output wr_valid, wr_x, wr_y, wr_color,
        input  wr_ready, wr_drop
    );

    modport slave (
        input  wr_valid, wr_x, wr_y, wr_color,
        output wr_ready, wr_drop
    );
endinterface

// File: rtl/fb_bank.sv
// One frame bank: FB_DEPTH words, one synchronous write port and one
// registered read port.
module fb_bank
    import fb_pkg::*;
#(
    parameter int W = 9
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [FB_ADDR_W-1:0] wr_addr_i,
    input  logic [W-1:0]         wr_data_i,
    input  logic [FB_ADDR_W-1:0] rd_addr_i,
    output logic [W-1:0]         rd_data_o
);
    logic [W-1:0] mem_q [FB_DEPTH];

    // NOTE: the array has no reset branch so it maps onto block RAM; a reset
    // loop over 76800 words would force it into flops.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        rd_data_o <= mem_q[rd_addr_i];
    end

endmodule

// File: rtl/frame_buffer.sv
// Double-buffered pixel store: rasterizer writes/clears the back bank, the VGA
// scan reads the front bank, and the banks swap only on a vsync falling edge.
module frame_buffer
    import fb_pkg::*;
#(
    parameter int CH_BITS = 3
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic [8:0]           x,
    input  logic [7:0]           y,
    input  logic                 vga_vs,
    frame_buffer_if.slave        wr,
    input  logic                 clear_req,
    input  logic [3*CH_BITS-1:0] clear_color,
    input  logic                 swap_req,
    output logic                 busy,
    output logic                 swap_done,
    output logic                 front_sel,
    output logic [9:0]           pix_r,
    output logic [9:0]           pix_g,
    output logic [9:0]           pix_b
);
    localparam int PIX_W = 3 * CH_BITS;

    fb_state_e            state_q;
    logic [FB_ADDR_W-1:0] clr_cnt_q;
    logic [PIX_W-1:0]     clr_color_q;
    logic                 front_sel_q;
    logic                 vs_q;
    logic                 busy_q;
    logic                 swap_done_q;
    logic                 wr_drop_q;

    logic wr_fire;
    logic wr_in_range;
    logic vs_edge;

    assign wr.wr_ready  = (state_q == IDLE) && !clear_req && !swap_req;
    assign wr_fire      = wr.wr_valid && wr.wr_ready;
    assign wr_in_range  = in_frame(wr.wr_x, wr.wr_y);
    assign vs_edge      = vs_q && !vga_vs;

    // NOTE: sequential state uses <= so every register samples pre-edge values
    // regardless of statement order inside the block.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= IDLE;
            clr_cnt_q   <= '0;
            clr_color_q <= '0;
            front_sel_q <= 1'b0;
            vs_q        <= 1'b1;
            busy_q      <= 1'b0;
            swap_done_q <= 1'b0;
            wr_drop_q   <= 1'b0;
        end else begin
            vs_q        <= vga_vs;
            swap_done_q <= 1'b0;
            wr_drop_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (clear_req) begin
                        state_q     <= CLEAR;
                        clr_cnt_q   <= '0;
                        clr_color_q <= clear_color;
                        busy_q      <= 1'b1;
                    end else if (swap_req) begin
                        state_q <= SWAP_WAIT;
                        busy_q  <= 1'b1;
                    end else if (wr_fire && !wr_in_range) begin
                        wr_drop_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (clr_cnt_q == FB_ADDR_W'(FB_DEPTH - 1)) begin
                        state_q   <= IDLE;
                        clr_cnt_q <= '0;
                        busy_q    <= 1'b0;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + 1'b1;
                    end
                end
                SWAP_WAIT: begin
                    if (vs_edge) begin
                        state_q     <= IDLE;
                        front_sel_q <= ~front_sel_q;
                        swap_done_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign swap_done   = swap_done_q;
    assign front_sel   = front_sel_q;
    assign wr.wr_drop  = wr_drop_q;

    // Back-bank write port: the clear sweep owns it while in CLEAR.
    logic                 bank_we;
    logic [FB_ADDR_W-1:0] bank_wr_addr;
    logic [PIX_W-1:0]     bank_wr_data;

    // NOTE: every output gets a default before the branches, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        bank_we      = 1'b0;
        bank_wr_addr = clr_cnt_q;
        bank_wr_data = clr_color_q;
        if (state_q == CLEAR) begin
            bank_we = 1'b1;
        end else if (wr_fire && wr_in_range) begin
            bank_we      = 1'b1;
            bank_wr_addr = fb_addr(wr.wr_x, wr.wr_y);
            bank_wr_data = wr.wr_color;
        end
    end

    // Read pipeline: stage 1 registers address/flag/bank, stage 2 is the RAM
    // output register plus the matching flag and bank select.
    logic                 rd_valid_d;
    logic [FB_ADDR_W-1:0] rd_addr_d;
    logic                 rd_valid_q;
    logic [FB_ADDR_W-1:0] rd_addr_q;
    logic                 rd_sel_q;
    logic                 pix_valid_q;
    logic                 pix_sel_q;

    assign rd_valid_d = in_frame(x, y);
    assign rd_addr_d  = rd_valid_d ? fb_addr(x, y) : '0;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            rd_valid_q  <= 1'b0;
            rd_addr_q   <= '0;
            rd_sel_q    <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_sel_q   <= 1'b0;
        end else begin
            rd_valid_q  <= rd_valid_d;
            rd_addr_q   <= rd_addr_d;
            rd_sel_q    <= front_sel_q;
            pix_valid_q <= rd_valid_q;
            pix_sel_q   <= rd_sel_q;
        end
    end

    logic [PIX_W-1:0] bank0_rd;
    logic [PIX_W-1:0] bank1_rd;

    fb_bank #(.W(PIX_W)) u_bank0 (
        .clk_i     (CLOCK_50),
        .we_i      (bank_we && front_sel_q),
        .wr_addr_i (bank_wr_addr),
        .wr_data_i (bank_wr_data),
        .rd_addr_i (rd_addr_q),
        .rd_data_o (bank0_rd)
    );

    fb_bank #(.W(PIX_W)) u_bank1 (
        .clk_i     (CLOCK_50),
        .we_i      (bank_we && !front_sel_q),
        .wr_addr_i (bank_wr_addr),
        .wr_data_i (bank_wr_data),
        .rd_addr_i (rd_addr_q),
        .rd_data_o (bank1_rd)
    );

    logic [PIX_W-1:0] pix_word;
    assign pix_word = pix_sel_q ? bank1_rd : bank0_rd;

    assign pix_r = pix_valid_q ? expand_ch(10'(pix_word[3*CH_BITS-1:2*CH_BITS]), CH_BITS) : '0;
    assign pix_g = pix_valid_q ? expand_ch(10'(pix_word[2*CH_BITS-1:CH_BITS]), CH_BITS) : '0;
    assign pix_b = pix_valid_q ? expand_ch(10'(pix_word[CH_BITS-1:0]), CH_BITS) : '0;

endmodule

// File: tb/tb_frame_buffer.sv
// Directed bench for frame_buffer: reset, write+swap, full clear, drops and
// back-to-back writes, request collisions and reset abandoning a swap.
module tb_frame_buffer;
    localparam int CH_BITS = 3;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b1;
    logic [8:0]  x = '0;
    logic [7:0]  y = '0;
    logic        vga_vs = 1'b1;
    logic        clear_req = 1'b0;
    logic [8:0]  clear_color = '0;
    logic        swap_req = 1'b0;
    logic        busy;
    logic        swap_done;
    logic        front_sel;
    logic [9:0]  pix_r;
    logic [9:0]  pix_g;
    logic [9:0]  pix_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    frame_buffer_if #(.CH_BITS(CH_BITS)) wr_bus ();

    frame_buffer #(.CH_BITS(CH_BITS)) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .x           (x),
        .y           (y),
        .vga_vs      (vga_vs),
        .wr          (wr_bus),
        .clear_req   (clear_req),
        .clear_color (clear_color),
        .swap_req    (swap_req),
        .busy        (busy),
        .swap_done   (swap_done),
        .front_sel   (front_sel),
        .pix_r       (pix_r),
        .pix_g       (pix_g),
        .pix_b       (pix_b)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    task automatic test_reset;
        wr_bus.wr_valid = 1'b0; wr_bus.wr_x = '0; wr_bus.wr_y = '0; wr_bus.wr_color = '0;
        reset = 1'b1; vga_vs = 1'b1; x = 9'd0; y = 8'd0;
        tick(3);
        reset = 1'b0;
        #1;
        vectors++; if (pix_r !== 10'h0) begin miscompares++; $display("FAIL reset_pix_r: got %h expected %h", pix_r, 10'h0); end
        vectors++; if (pix_g !== 10'h0) begin miscompares++; $display("FAIL reset_pix_g: got %h expected %h", pix_g, 10'h0); end
        vectors++; if (pix_b !== 10'h0) begin miscompares++; $display("FAIL reset_pix_b: got %h expected %h", pix_b, 10'h0); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (front_sel !== 1'b0) begin miscompares++; $display("FAIL reset_front_sel: got %b expected 0", front_sel); end
        vectors++; if (wr_bus.wr_ready !== 1'b1) begin miscompares++; $display("FAIL reset_wr_ready: got %b expected 1", wr_bus.wr_ready); end
        vectors++; if (swap_done !== 1'b0) begin miscompares++; $display("FAIL reset_swap_done: got %b expected 0", swap_done); end
        vectors++; if (wr_bus.wr_drop !== 1'b0) begin miscompares++; $display("FAIL reset_wr_drop: got %b expected 0", wr_bus.wr_drop); end
    endtask

    // Write (10,5) into bank 1, swap with a same-cycle vsync edge that must be ignored.
    task automatic test_write_swap;
        wr_bus.wr_valid = 1'b1; wr_bus.wr_x = 9'd10; wr_bus.wr_y = 8'd5; wr_bus.wr_color = 9'h1C0;
        #1;
        vectors++; if (wr_bus.wr_ready !== 1'b1) begin miscompares++; $display("FAIL ws_wr_ready: got %b expected 1", wr_bus.wr_ready); end
        tick();
        wr_bus.wr_valid = 1'b0;
        vectors++; if (wr_bus.wr_drop !== 1'b0) begin miscompares++; $display("FAIL ws_no_drop: got %b expected 0", wr_bus.wr_drop); end
        swap_req = 1'b1; vga_vs = 1'b0;
        #1;
        vectors++; if (wr_bus.wr_ready !== 1'b0) begin miscompares++; $display("FAIL ws_ready_swapreq: got %b expected 0", wr_bus.wr_ready); end
        tick();
        swap_req = 1'b0;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL ws_busy: got %b expected 1", busy); end
        vectors++; if (swap_done !== 1'b0) begin miscompares++; $display("FAIL ws_same_cycle_edge: got %b expected 0", swap_done); end
        tick();
        vectors++; if (swap_done !== 1'b0) begin miscompares++; $display("FAIL ws_vs_low_held: got %b expected 0", swap_done); end
        vga_vs = 1'b1;
        tick();
        vga_vs = 1'b0;
        tick();
        vectors++; if (swap_done !== 1'b1) begin miscompares++; $display("FAIL ws_swap_done: got %b expected 1", swap_done); end
        vectors++; if (front_sel !== 1'b1) begin miscompares++; $display("FAIL ws_front_sel: got %b expected 1", front_sel); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ws_busy_after: got %b expected 0", busy); end
        vga_vs = 1'b1;
        tick();
        vectors++; if (swap_done !== 1'b0) begin miscompares++; $display("FAIL ws_swap_done_pulse: got %b expected 0", swap_done); end
        x = 9'd320; y = 8'd5;
        tick(2);
        vectors++; if ({pix_r, pix_g, pix_b} !== 30'h0) begin miscompares++; $display("FAIL ws_x320_black: got %h expected %h", {pix_r, pix_g, pix_b}, 30'h0); end
        x = 9'd10;
        tick();
        vectors++; if (pix_r !== 10'h0) begin miscompares++; $display("FAIL ws_latency_1: got %h expected %h", pix_r, 10'h0); end
        tick();
        vectors++; if (pix_r !== 10'h3FF) begin miscompares++; $display("FAIL ws_pix_r: got %h expected %h", pix_r, 10'h3FF); end
        vectors++; if (pix_g !== 10'h0) begin miscompares++; $display("FAIL ws_pix_g: got %h expected %h", pix_g, 10'h0); end
        vectors++; if (pix_b !== 10'h0) begin miscompares++; $display("FAIL ws_pix_b: got %h expected %h", pix_b, 10'h0); end
    endtask

    // Clear bank 0 to white, count busy cycles, swap it to the front and sample corners.
    task automatic test_clear;
        int n;
        int ready_bad;
        clear_req = 1'b1; clear_color = 9'h1FF;
        #1;
        vectors++; if (wr_bus.wr_ready !== 1'b0) begin miscompares++; $display("FAIL clr_ready_req: got %b expected 0", wr_bus.wr_ready); end
        tick();
        clear_req = 1'b0; clear_color = 9'h000;
        wr_bus.wr_valid = 1'b1; wr_bus.wr_x = 9'd0; wr_bus.wr_y = 8'd0; wr_bus.wr_color = 9'h000;
        n = 0; ready_bad = 0;
        while (busy === 1'b1 && n < 80000) begin
            n++;
            if (wr_bus.wr_ready !== 1'b0) ready_bad++;
            tick();
        end
        wr_bus.wr_valid = 1'b0;
        vectors++; if (n !== 76800) begin miscompares++; $display("FAIL clr_busy_cycles: got %0d expected %0d", n, 76800); end
        vectors++; if (ready_bad !== 0) begin miscompares++; $display("FAIL clr_ready_low: got %0d ready cycles expected 0", ready_bad); end
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0; vga_vs = 1'b0;
        tick();
        vectors++; if (swap_done !== 1'b1) begin miscompares++; $display("FAIL clr_swap_done: got %b expected 1", swap_done); end
        vectors++; if (front_sel !== 1'b0) begin miscompares++; $display("FAIL clr_front_sel: got %b expected 0", front_sel); end
        vga_vs = 1'b1;
        tick();
        x = 9'd0; y = 8'd0;
        tick(2);
        vectors++; if ({pix_r, pix_g, pix_b} !== {3{10'h3FF}}) begin miscompares++; $display("FAIL clr_pix_0_0: got %h expected %h", {pix_r, pix_g, pix_b}, {3{10'h3FF}}); end
        x = 9'd319; y = 8'd239;
        tick(2);
        vectors++; if ({pix_r, pix_g, pix_b} !== {3{10'h3FF}}) begin miscompares++; $display("FAIL clr_pix_319_239: got %h expected %h", {pix_r, pix_g, pix_b}, {3{10'h3FF}}); end
    endtask

    // Back-to-back writes into bank 1, including two out-of-range drops; 320,0 aliases (0,1).
    task automatic test_back_to_back_drop;
        wr_bus.wr_valid = 1'b1;
        wr_bus.wr_x = 9'd319; wr_bus.wr_y = 8'd239; wr_bus.wr_color = 9'h124;
        #1;
        vectors++; if (wr_bus.wr_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_0: got %b expected 1", wr_bus.wr_ready); end
        tick();
        vectors++; if (wr_bus.wr_drop !== 1'b0) begin miscompares++; $display("FAIL b2b_drop_0: got %b expected 0", wr_bus.wr_drop); end
        wr_bus.wr_x = 9'd0; wr_bus.wr_y = 8'd1; wr_bus.wr_color = 9'h159;
        tick();
        vectors++; if (wr_bus.wr_drop !== 1'b0) begin miscompares++; $display("FAIL b2b_drop_1: got %b expected 0", wr_bus.wr_drop); end
        wr_bus.wr_x = 9'd320; wr_bus.wr_y = 8'd0; wr_bus.wr_color = 9'h1FF;
        #1;
        vectors++; if (wr_bus.wr_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_oor: got %b expected 1", wr_bus.wr_ready); end
        tick();
        vectors++; if (wr_bus.wr_drop !== 1'b1) begin miscompares++; $display("FAIL b2b_drop_x320: got %b expected 1", wr_bus.wr_drop); end
        wr_bus.wr_x = 9'd0; wr_bus.wr_y = 8'd240;
        tick();
        vectors++; if (wr_bus.wr_drop !== 1'b1) begin miscompares++; $display("FAIL b2b_drop_y240: got %b expected 1", wr_bus.wr_drop); end
        wr_bus.wr_valid = 1'b0;
        tick();
        vectors++; if (wr_bus.wr_drop !== 1'b0) begin miscompares++; $display("FAIL b2b_drop_clear: got %b expected 0", wr_bus.wr_drop); end
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0; vga_vs = 1'b0;
        tick();
        vectors++; if (front_sel !== 1'b1) begin miscompares++; $display("FAIL b2b_front_sel: got %b expected 1", front_sel); end
        vga_vs = 1'b1;
        tick();
        x = 9'd0; y = 8'd1;
        tick(2);
        vectors++; if (pix_r !== 10'h2DB) begin miscompares++; $display("FAIL b2b_alias_r: got %h expected %h", pix_r, 10'h2DB); end
        vectors++; if (pix_g !== 10'h1B6) begin miscompares++; $display("FAIL b2b_alias_g: got %h expected %h", pix_g, 10'h1B6); end
        vectors++; if (pix_b !== 10'h092) begin miscompares++; $display("FAIL b2b_alias_b: got %h expected %h", pix_b, 10'h092); end
        x = 9'd319; y = 8'd239;
        tick(2);
        vectors++; if ({pix_r, pix_g, pix_b} !== {3{10'h249}}) begin miscompares++; $display("FAIL b2b_corner: got %h expected %h", {pix_r, pix_g, pix_b}, {3{10'h249}}); end
        x = 9'd10; y = 8'd5;
        tick(2);
        vectors++; if ({pix_r, pix_g, pix_b} !== {10'h3FF, 20'h0}) begin miscompares++; $display("FAIL b2b_keep_10_5: got %h expected %h", {pix_r, pix_g, pix_b}, {10'h3FF, 20'h0}); end
    endtask

    // clear_req wins over swap_req; a vsync edge during CLEAR must not swap.
    task automatic test_clear_swap_collide;
        clear_req = 1'b1; swap_req = 1'b1; clear_color = 9'h000;
        #1;
        vectors++; if (wr_bus.wr_ready !== 1'b0) begin miscompares++; $display("FAIL col_ready: got %b expected 0", wr_bus.wr_ready); end
        tick();
        clear_req = 1'b0; swap_req = 1'b0;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL col_busy: got %b expected 1", busy); end
        vga_vs = 1'b0;
        tick();
        vectors++; if (swap_done !== 1'b0) begin miscompares++; $display("FAIL col_no_swap_done: got %b expected 0", swap_done); end
        vga_vs = 1'b1;
        tick();
        vectors++; if (front_sel !== 1'b1) begin miscompares++; $display("FAIL col_front_sel: got %b expected 1", front_sel); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL col_still_clearing: got %b expected 1", busy); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL col_abort_busy: got %b expected 0", busy); end
        vectors++; if (front_sel !== 1'b0) begin miscompares++; $display("FAIL col_abort_front: got %b expected 0", front_sel); end
    endtask

    // Reset during SWAP_WAIT abandons the swap.
    task automatic test_reset_swap_wait;
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rsw_busy: got %b expected 1", busy); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rsw_busy_after: got %b expected 0", busy); end
        vectors++; if (wr_bus.wr_ready !== 1'b1) begin miscompares++; $display("FAIL rsw_ready: got %b expected 1", wr_bus.wr_ready); end
        vga_vs = 1'b0;
        tick();
        vectors++; if (swap_done !== 1'b0) begin miscompares++; $display("FAIL rsw_no_swap_done: got %b expected 0", swap_done); end
        vectors++; if (front_sel !== 1'b0) begin miscompares++; $display("FAIL rsw_front_sel: got %b expected 0", front_sel); end
        vga_vs = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_write_swap();
        test_clear();
        test_back_to_back_drop();
        test_clear_swap_collide();
        test_reset_swap_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no completion expected summary");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/frame_buffer.md
# frame_buffer

Double-buffered 320x240 pixel store between the rasterizer and the VGA timing controller. The rasterizer writes pixels into the back buffer through a valid/ready port, and can request a full back-buffer clear. The VGA controller's (x, y) scan coordinates read the front buffer, producing 10-bit R/G/B for its colour inputs. Front and back swap only during vertical sync, so a frame is never shown half-drawn.

## Interface
- CH_BITS, 3, bits per colour channel stored; a pixel is 3*CH_BITS bits, {R,G,B}, R in the MSBs.
- CLOCK_50  in  1  system clock; the VGA controller runs from the same clock.
- reset  in  1  synchronous, active-high.
- x  in  9  scan column from the VGA controller, 0..399 (320x240 mode).
- y  in  8  scan row from the VGA controller, 0..262.
- vga_vs  in  1  VGA_VS from the controller, active-low.
- wr_valid  in  1  rasterizer pixel write request.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- wr_x  in  9  write column.
- wr_y  in  8  write row.
- wr_color  in  3*CH_BITS  write pixel.
- wr_drop  out  1  one-cycle pulse: an accepted write was out of range and discarded.
- clear_req  in  1  pulse: fill the back buffer with clear_color.
- clear_color  in  3*CH_BITS  fill value, sampled on the cycle clear_req is accepted.
- swap_req  in  1  pulse: swap buffers at the next vsync.
- busy  out  1  high in CLEAR or SWAP_WAIT.
- swap_done  out  1  one-cycle pulse when the swap takes effect.
- front_sel  out  1  index of the displayed bank.
- pix_r, pix_g, pix_b  out  10 each  expanded colour for the VGA controller's R/G/B inputs.

## Operation
- FSM states:
  - IDLE → CLEAR on clear_req.
  - IDLE → SWAP_WAIT on swap_req with no clear_req.
  - CLEAR → IDLE after the write to address 76799.
  - SWAP_WAIT → IDLE on a vsync edge.
- Priority in IDLE: clear_req > swap_req > write. A losing or non-IDLE request is dropped; callers must check busy.
- wr_ready = (state==IDLE) && !clear_req && !swap_req. It is combinational.
- Address = y*320 + x, 17 bits, computed as (y<<8)+(y<<6)+x.
- Accepted write with wr_x<320 and wr_y<240: the back bank is written on that clock edge.
- Accepted write out of range: no memory write; wr_drop=1 on the next cycle.
- CLEAR: a clear counter runs 0..76799, writing the latched clear_color to the back bank one word per cycle. The clear takes exactly 76800 cycles.
- Vsync edge: vs_q is the registered vga_vs; the edge is vs_q && !vga_vs. An edge in the same cycle swap_req is accepted does not count; the swap waits for the following edge.
- On the edge in SWAP_WAIT: front_sel toggles, swap_done=1 for one cycle, state returns to IDLE.
- Read path: the front bank is read at address(x, y) every cycle.
- Coordinates with x≥320 or y≥240 output 0 on all channels.
- Channel expansion: bit replication MSB-first to 10 bits, out[9-i] = c[CH_BITS-1-(i mod CH_BITS)]. Examples: 3'b101 → 10'h2DB; 3'b111 → 10'h3FF.
- Reset values:
  - state IDLE, front_sel 0, vs_q 1, clear counter 0.
  - busy 0, swap_done 0, wr_drop 0, pix_* 0.
  - RAM contents are not reset.
- Reset mid-CLEAR or mid-SWAP_WAIT: the operation is abandoned, memory is left partially written, and front_sel returns to 0.

## Timing
- Read latency is 2 cycles: x/y are registered into the address and range flag, then RAM data and the flag are registered, then expanded combinationally.
- A change of x/y at edge N appears on pix_* after edge N+2.
- The controller's HS/VS/BLANK are also delayed 2 cycles, so pixels stay aligned with sync.
- Write: one pixel per cycle at full throughput while IDLE with no requests pending.
- Front and back are always different banks, so reads never collide with writes.
- swap_done rises on the cycle after the qualifying vga_vs falling edge is sampled. The front_sel change is visible on pix_* 2 cycles later.

## Structure
- Package fb_pkg:
  - FB_WIDTH=320, FB_HEIGHT=240, FB_DEPTH=76800, FB_ADDR_W=17.
  - State enum {IDLE, CLEAR, SWAP_WAIT}.
  - Channel-expansion function.
- Sub-module fb_bank: simple dual-port RAM, FB_DEPTH x 3*CH_BITS, with one synchronous write port and one registered read port. It is instantiated twice.
- The top level holds the FSM, address arithmetic, bank muxing and colour expansion.

## Test plan
- Reset, then drive x=0, y=0 with vga_vs=1 → pix_* = 0, busy=0, front_sel=0, wr_ready=1.
- Write (10,5) = 9'h1C0, swap_req, vga_vs 1→0 → swap_done one cycle later, front_sel=1. Then x=10, y=5 gives pix_r=3FF, pix_g=0, pix_b=0 two cycles after.
- clear_req with clear_color=9'h1FF → busy for exactly 76800 cycles and wr_ready=0 throughout. After a swap, pixels (0,0) and (319,239) read 3FF/3FF/3FF.
- Write with wr_x=320 → handshake completes and wr_drop pulses. Reading (0,1), which would alias address 320, is unchanged.
- clear_req and swap_req in the same cycle → CLEAR entered, swap ignored, no swap_done.
- swap_req in SWAP_WAIT, then reset asserted for 1 cycle → state IDLE, front_sel=0, no swap_done on the next vsync.
